// File: rtl/sync_pkg.sv
// Shared encodings and helpers for the fast-to-slow launcher.
// State codes for the transfer FSM plus a constant clog2.
package sync_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_SETUP = 2'd1;
  localparam state_t S_HIGH  = 2'd2;
  localparam state_t S_LOW   = 2'd3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_hold_slot.sv
// One-entry pending register: data plus valid flag.
// Ports: i_clk, i_rst (sync, high), i_load, i_take, i_data -> o_full, o_data.
module sync_hold_slot #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic                  i_take,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_full,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  r_full;
  logic [DATA_WIDTH-1:0] r_data;

  // Load wins over take: a drain and refill in one cycle stays full.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (i_take) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;

endmodule

// File: rtl/sync_f2s_simple.sv
// Fast-side launcher: holds slow_data and stretches slow_data_set for a slow consumer.
// Ports: fast_clk, fast_rst, fast_data, fast_data_set -> fast_busy, fast_drop, slow_data, slow_data_set.
module sync_f2s_simple
  import sync_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int CLK_RATIO        = 4,
  parameter int HOLD_SLOW_CYCLES = 2
) (
  input  logic                  fast_clk,
  input  logic                  fast_rst,
  input  logic [DATA_WIDTH-1:0] fast_data,
  input  logic                  fast_data_set,
  output logic                  fast_busy,
  output logic                  fast_drop,
  output logic [DATA_WIDTH-1:0] slow_data,
  output logic                  slow_data_set
);

  localparam int H  = CLK_RATIO * HOLD_SLOW_CYCLES;
  localparam int CW = clog2(H + 1);
  localparam logic [CW-1:0] C_SETUP = CW'(CLK_RATIO - 1);
  localparam logic [CW-1:0] C_HOLD  = CW'(H - 1);

  generate
    if (CLK_RATIO < 4 || HOLD_SLOW_CYCLES < 2) begin : g_bad_param
      $error("sync_f2s_simple: CLK_RATIO >= 4 and HOLD_SLOW_CYCLES >= 2 required");
    end
  endgenerate

  state_t                r_state;
  state_t                w_nxt;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_ld;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_set;
  logic                  r_busy;
  logic                  r_drop;

  logic                  w_cnt_zero;
  logic                  w_last_low;
  logic                  w_launch_req;
  logic                  w_launch_slot;
  logic                  w_launch;
  logic                  w_load;
  logic                  w_take;
  logic                  w_drop;
  logic                  w_full;
  logic                  w_full_nxt;
  logic [DATA_WIDTH-1:0] w_slot_data;
  logic [DATA_WIDTH-1:0] w_ld_data;

  sync_hold_slot #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_slot (
    .i_clk (fast_clk),
    .i_rst (fast_rst),
    .i_load(w_load),
    .i_take(w_take),
    .i_data(fast_data),
    .o_full(w_full),
    .o_data(w_slot_data)
  );

  assign w_cnt_zero = (r_cnt == '0);
  assign w_last_low = (r_state == S_LOW) && w_cnt_zero;

  // Request routing. On the last LOW cycle an empty slot lets a new
  // request launch directly so it never strands in the slot at IDLE.
  always_comb begin
    w_launch_req  = 1'b0;
    w_launch_slot = 1'b0;
    w_load        = 1'b0;
    w_drop        = 1'b0;
    unique case (1'b1)
      (r_state == S_IDLE): begin
        w_launch_req = fast_data_set;
      end
      w_last_low: begin
        w_launch_slot = w_full;
        w_launch_req  = fast_data_set & ~w_full;
        w_load        = fast_data_set & w_full;
      end
      default: begin
        w_load = fast_data_set & ~w_full;
        w_drop = fast_data_set & w_full;
      end
    endcase
  end

  assign w_take     = w_launch_slot;
  assign w_launch   = w_launch_req | w_launch_slot;
  assign w_ld_data  = w_launch_slot ? w_slot_data : fast_data;
  assign w_full_nxt = w_load | (w_full & ~w_take);

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_launch_req) w_nxt = S_SETUP;
      S_SETUP: if (w_cnt_zero) w_nxt = S_HIGH;
      S_HIGH:  if (w_cnt_zero) w_nxt = S_LOW;
      S_LOW: begin
        if (w_cnt_zero) w_nxt = w_launch ? S_SETUP : S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_ld = '0;
    unique case (w_nxt)
      S_SETUP: w_cnt_ld = C_SETUP;
      S_HIGH:  w_cnt_ld = C_HOLD;
      S_LOW:   w_cnt_ld = C_HOLD;
      default: w_cnt_ld = '0;
    endcase
  end

  always_ff @(posedge fast_clk) begin
    if (fast_rst) r_state <= S_IDLE;
    else          r_state <= w_nxt;
  end

  // Counter reloads on every state change, including LOW -> SETUP.
  always_ff @(posedge fast_clk) begin
    if (fast_rst) begin
      r_cnt  <= '0;
      r_data <= '0;
      r_set  <= 1'b0;
      r_busy <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      if (w_nxt != r_state) r_cnt <= w_cnt_ld;
      else if (!w_cnt_zero) r_cnt <= r_cnt - 1'b1;
      if (w_launch) r_data <= w_ld_data;
      r_set  <= (w_nxt == S_HIGH);
      r_busy <= (w_nxt != S_IDLE) | w_full_nxt;
      r_drop <= w_drop;
    end
  end

  assign slow_data     = r_data;
  assign slow_data_set = r_set;
  assign fast_busy     = r_busy;
  assign fast_drop     = r_drop;

endmodule

// File: tb/tb_sync_f2s_simple.sv
// Scoreboard bench for sync_f2s_simple: directed timing plus random stream.
// A slow-domain edge detector pops expected words; drops are checked by cycle.
module tb_sync_f2s_simple;

  localparam int DW = 8;
  localparam int R  = 4;
  localparam int HS = 2;
  localparam int H  = R * HS;

  logic          fast_clk = 1'b0;
  logic          slow_clk = 1'b0;
  logic          fast_rst = 1'b1;
  logic [DW-1:0] fast_data = '0;
  logic          fast_data_set = 1'b0;
  logic          fast_busy;
  logic          fast_drop;
  logic [DW-1:0] slow_data;
  logic          slow_data_set;

  sync_f2s_simple #(
    .DATA_WIDTH      (DW),
    .CLK_RATIO       (R),
    .HOLD_SLOW_CYCLES(HS)
  ) dut (
    .fast_clk     (fast_clk),
    .fast_rst     (fast_rst),
    .fast_data    (fast_data),
    .fast_data_set(fast_data_set),
    .fast_busy    (fast_busy),
    .fast_drop    (fast_drop),
    .slow_data    (slow_data),
    .slow_data_set(slow_data_set)
  );

  initial forever #5 fast_clk = ~fast_clk;
  initial begin
    #3;
    forever #20 slow_clk = ~slow_clk;
  end

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always @(posedge fast_clk) cyc <= cyc + 1;

  logic [DW-1:0] exp_q[$];
  int            drop_q[$];
  int            t_end = -1;
  bit            pv = 1'b0;
  logic [DW-1:0] pd = '0;
  bit            exp_busy = 1'b0;
  bit            mon_en = 1'b1;

  function automatic void chk(input string nm, input logic [31:0] got,
                              input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endfunction

  function automatic void launch(input logic [DW-1:0] x);
    exp_q.push_back(x);
    t_end = cyc + R + 2 * H;
  endfunction

  // Time-based reference: t_end is the last LOW cycle of the live transfer.
  function automatic void model(input bit v, input logic [DW-1:0] d,
                                input bit r);
    if (r) begin
      t_end    = -1;
      pv       = 1'b0;
      exp_busy = 1'b0;
      return;
    end
    if (cyc == t_end) begin
      if (pv) begin
        launch(pd);
        pv = v;
        if (v) pd = d;
      end else if (v) begin
        launch(d);
      end
    end else if (cyc > t_end) begin
      if (v) launch(d);
    end else if (v) begin
      if (!pv) begin
        pv = 1'b1;
        pd = d;
      end else begin
        drop_q.push_back(cyc + 1);
      end
    end
    exp_busy = (cyc + 1 <= t_end) || pv;
  endfunction

  task automatic step(input bit v, input logic [DW-1:0] d, input bit r);
    fast_data_set = v;
    fast_data     = d;
    fast_rst      = r;
    model(v, d, r);
    @(posedge fast_clk);
    #1;
    fast_data_set = 1'b0;
    fast_rst      = 1'b0;
    chk("busy_model", {31'd0, fast_busy}, {31'd0, exp_busy});
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((cyc <= t_end || pv) && guard < 200) begin
      step(1'b0, '0, 1'b0);
      guard++;
    end
    repeat (20) step(1'b0, '0, 1'b0);
  endtask

  // Slow consumer: 2-flop synchroniser plus rising-edge detect.
  logic s1 = 1'b0;
  logic s2 = 1'b0;
  logic s3 = 1'b0;

  always @(posedge slow_clk) begin
    s1 <= slow_data_set;
    s2 <= s1;
    s3 <= s2;
    if (s2 && !s3 && mon_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL slow_rx: got %0h expected none", slow_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (slow_data !== e) begin
          fails++;
          $display("FAIL slow_rx: got %0h expected %0h", slow_data, e);
        end
      end
    end
  end

  always @(negedge fast_clk) begin
    if (fast_drop === 1'b1) begin
      checks++;
      if (drop_q.size() == 0) begin
        fails++;
        $display("FAIL drop: got pulse at %0d expected none", cyc);
      end else begin
        int e;
        e = drop_q.pop_front();
        if (cyc != e) begin
          fails++;
          $display("FAIL drop: got cycle %0d expected %0d", cyc, e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge fast_clk);
    #1;
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("rst_data", {24'd0, slow_data}, 32'd0);
    chk("rst_set", {31'd0, slow_data_set}, 32'd0);
    chk("rst_busy", {31'd0, fast_busy}, 32'd0);
    chk("rst_drop", {31'd0, fast_drop}, 32'd0);
    repeat (4) step(1'b0, '0, 1'b0);

    // single request
    step(1'b1, 8'hA5, 1'b0);
    for (int c = 1; c <= 24; c++) begin
      chk("t1_data", {24'd0, slow_data}, 32'hA5);
      chk("t1_set", {31'd0, slow_data_set}, {31'd0, c >= 5 && c <= 12});
      chk("t1_busy", {31'd0, fast_busy}, {31'd0, c <= 20});
      step(1'b0, '0, 1'b0);
    end
    drain();

    // pending slot
    step(1'b1, 8'h11, 1'b0);
    for (int c = 1; c <= 45; c++) begin
      chk("t2_data", {24'd0, slow_data}, (c < 21) ? 32'h11 : 32'h22);
      chk("t2_set", {31'd0, slow_data_set},
          {31'd0, (c >= 5 && c <= 12) || (c >= 25 && c <= 32)});
      chk("t2_busy", {31'd0, fast_busy}, {31'd0, c <= 40});
      step(c == 3, 8'h22, 1'b0);
    end
    drain();

    // overflow drop
    step(1'b1, 8'h11, 1'b0);
    for (int c = 1; c <= 45; c++) begin
      chk("t3_drop", {31'd0, fast_drop}, {31'd0, c == 3});
      chk("t3_data", {24'd0, slow_data}, (c < 21) ? 32'h11 : 32'h22);
      step(c == 1 || c == 2, (c == 1) ? 8'h22 : 8'h33, 1'b0);
    end
    drain();

    // request on last LOW cycle with slot full
    step(1'b1, 8'h11, 1'b0);
    for (int c = 1; c <= 62; c++) begin
      chk("t4_data", {24'd0, slow_data},
          (c < 21) ? 32'h11 : (c < 41) ? 32'h22 : 32'h33);
      chk("t4_drop", {31'd0, fast_drop}, 32'd0);
      chk("t4_busy", {31'd0, fast_busy}, {31'd0, c <= 60});
      step(c == 1 || c == 20, (c == 1) ? 8'h22 : 8'h33, 1'b0);
    end
    drain();

    // reset during HIGH
    mon_en = 1'b0;
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    repeat (3) step(1'b0, '0, 1'b0);
    chk("t5_set_hi", {31'd0, slow_data_set}, 32'd1);
    step(1'b0, '0, 1'b1);
    chk("t5_set", {31'd0, slow_data_set}, 32'd0);
    chk("t5_data", {24'd0, slow_data}, 32'd0);
    chk("t5_busy", {31'd0, fast_busy}, 32'd0);
    repeat (16) step(1'b0, '0, 1'b0);
    exp_q.delete();
    mon_en = 1'b1;
    step(1'b1, 8'h5A, 1'b0);
    chk("t5_relaunch", {24'd0, slow_data}, 32'h5A);
    drain();

    // random stream
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 5)) step(1'b0, '0, 1'b0);
      step(1'b1, 8'($urandom), 1'b0);
    end
    drain();

    chk("rx_all", exp_q.size(), 32'd0);
    chk("drop_all", drop_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
